// File: rtl/rcc_osc_ker_req_ctrl_if.sv
// Request/ack and oscillator status bundle between the kernel clock
// requesters, the RCC register file and one on-demand oscillator controller.
interface rcc_osc_ker_req_ctrl_if #(
   parameter int unsigned REQ_NUM = 8
);
   logic [REQ_NUM-1:0] ker_clk_reqs;
   logic               sw_osc_on;
   logic               d3_deepsleep;
   logic               osc_stable_raw;
   logic               osc_en;
   logic               osc_rdy;
   logic [REQ_NUM-1:0] req_ack;
   logic               osc_fail;

   // Requester / register-file / analog side
   modport master (
      output ker_clk_reqs, sw_osc_on, d3_deepsleep, osc_stable_raw,
      input  osc_en, osc_rdy, req_ack, osc_fail
   );

   // Oscillator controller side
   modport slave (
      input  ker_clk_reqs, sw_osc_on, d3_deepsleep, osc_stable_raw,
      output osc_en, osc_rdy, req_ack, osc_fail
   );
endinterface

// File: rtl/rcc_osc_ker_req_ctrl.sv
// Oscillator-side responder for peripheral kernel clock requests.
// Merges request lines and the software ON bit into an oscillator enable,
// qualifies stability through a synchronizer plus stable-count filter,
// reports ready/acks, and delays switch-off across short demand gaps.
// Optional macro RCC_OSC_TIMEOUT_EN adds a sticky startup-timeout fail.
module rcc_osc_ker_req_ctrl #(
   parameter int unsigned REQ_NUM        = 8,
   parameter int unsigned STARTUP_CYCLES = 16,
   parameter int unsigned OFF_DELAY      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic                   i_clk,
   input logic                   sys_rst,
   rcc_osc_ker_req_ctrl_if.slave osc_if
);

   localparam int unsigned SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
   localparam int unsigned OW = (OFF_DELAY > 1) ? $clog2(OFF_DELAY) : 1;
   localparam logic [SW-1:0] STABLE_LAST = SW'(STARTUP_CYCLES - 1);
   localparam logic [OW-1:0] OFF_LAST    = OW'(OFF_DELAY - 1);

   typedef enum logic [1:0] {
      ST_OFF,
      ST_STARTUP,
      ST_ON,
      ST_HOLD
   } state_e;

   state_e          state_q, state_d;
   logic [SW-1:0]   stable_cnt_q, stable_cnt_d;
   logic [OW-1:0]   off_cnt_q, off_cnt_d;
   logic            sync1_q, stable_s_q;
   logic            osc_en_q, osc_en_d;
   logic            osc_rdy_q, osc_rdy_d;
   logic            demand;
   logic            fail_blk;

`ifdef RCC_OSC_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic            fail_q, fail_d;
   assign fail_blk = fail_q;
`else
   assign fail_blk = 1'b0;
`endif

   assign demand = (osc_if.sw_osc_on & ~osc_if.d3_deepsleep) | (|osc_if.ker_clk_reqs);

   // Two-flop synchronizer for the analog stable flag
   always_ff @(posedge i_clk) begin
      if (sys_rst) begin
         sync1_q    <= 1'b0;
         stable_s_q <= 1'b0;
      end else begin
         sync1_q    <= osc_if.osc_stable_raw;
         stable_s_q <= sync1_q;
      end
   end

   // Next-state, counter and registered-output computation
   always_comb begin
      state_d      = state_q;
      stable_cnt_d = stable_cnt_q;
      off_cnt_d    = off_cnt_q;
`ifdef RCC_OSC_TIMEOUT_EN
      tmo_cnt_d    = tmo_cnt_q;
      fail_d       = fail_q;
`endif
      case (state_q)
         ST_OFF: begin
            if (demand && !fail_blk) begin
               state_d      = ST_STARTUP;
               stable_cnt_d = '0;
`ifdef RCC_OSC_TIMEOUT_EN
               tmo_cnt_d    = '0;
`endif
            end
         end
         ST_STARTUP: begin
            if (!demand) begin
               state_d = ST_OFF;
            end else if (stable_s_q && (stable_cnt_q == STABLE_LAST)) begin
               state_d = ST_ON;
            end else begin
               if (!stable_s_q) begin
                  stable_cnt_d = '0;
               end else if (stable_cnt_q != STABLE_LAST) begin
                  stable_cnt_d = stable_cnt_q + 1'b1;
               end
`ifdef RCC_OSC_TIMEOUT_EN
               if (tmo_cnt_q == TMO_LAST) begin
                  state_d = ST_OFF;
                  fail_d  = 1'b1;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 1'b1;
               end
`endif
            end
         end
         ST_ON: begin
            if (!stable_s_q) begin
               state_d      = ST_STARTUP;
               stable_cnt_d = '0;
`ifdef RCC_OSC_TIMEOUT_EN
               tmo_cnt_d    = '0;
`endif
            end else if (!demand) begin
               state_d   = ST_HOLD;
               off_cnt_d = '0;
            end
         end
         ST_HOLD: begin
            if (!stable_s_q) begin
               state_d      = ST_STARTUP;
               stable_cnt_d = '0;
`ifdef RCC_OSC_TIMEOUT_EN
               tmo_cnt_d    = '0;
`endif
            end else if (demand) begin
               state_d   = ST_ON;
               off_cnt_d = '0;
            end else if (off_cnt_q == OFF_LAST) begin
               state_d = ST_OFF;
            end else begin
               off_cnt_d = off_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_OFF;
      endcase
      osc_en_d  = (state_d != ST_OFF);
      osc_rdy_d = (state_d == ST_ON) || (state_d == ST_HOLD);
   end

   // State, counter and output registers
   always_ff @(posedge i_clk) begin
      if (sys_rst) begin
         state_q      <= ST_OFF;
         stable_cnt_q <= '0;
         off_cnt_q    <= '0;
         osc_en_q     <= 1'b0;
         osc_rdy_q    <= 1'b0;
`ifdef RCC_OSC_TIMEOUT_EN
         tmo_cnt_q    <= '0;
         fail_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         stable_cnt_q <= stable_cnt_d;
         off_cnt_q    <= off_cnt_d;
         osc_en_q     <= osc_en_d;
         osc_rdy_q    <= osc_rdy_d;
`ifdef RCC_OSC_TIMEOUT_EN
         tmo_cnt_q    <= tmo_cnt_d;
         fail_q       <= fail_d;
`endif
      end
   end

   assign osc_if.osc_en  = osc_en_q;
   assign osc_if.osc_rdy = osc_rdy_q;
   assign osc_if.req_ack = osc_if.ker_clk_reqs & {REQ_NUM{osc_rdy_q}};
`ifdef RCC_OSC_TIMEOUT_EN
   assign osc_if.osc_fail = fail_q;
`else
   assign osc_if.osc_fail = 1'b0;
`endif

endmodule
